distance_store_arbiter: RTL and testbench

//   Sequences and shares the single DistanceStore between the two Dijkstra engines:

---
 rtl/distance_store_arbiter_if.sv | 23 ++
 rtl/distance_store_arbiter.sv | 154 +++++++++++++++
 tb/tb_distance_store_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/distance_store_arbiter_if.sv
// Requester <-> arbiter handshake for one single-word DistanceStore access port.
//   req    : request valid, held until gnt
//   we     : 1 = set (write), 0 = get (read)
//   index  : target node
//   wdata  : write distance
//   gnt    : request accepted this cycle (combinational)
//   rvalid : one-cycle read-data-valid pulse
//   rdata  : read data, 0 when rvalid is low
interface distance_store_arbiter_if #(
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 8
);
  logic                   req;
  logic                   we;
  logic [INDEX_WIDTH-1:0] index;
  logic [VALUE_WIDTH-1:0] wdata;
  logic                   gnt;
  logic                   rvalid;
  logic [VALUE_WIDTH-1:0] rdata;

  modport master (output req, we, index, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, index, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/distance_store_arbiter.sv
// Shares the single DistanceStore port between two Dijkstra engines.
// On init_start the store is swept (INF everywhere, 0 at the source), then
// single-word get/set requests from requesters a and b are round-robin
// arbitrated onto the store port.
//   clock, reset      : clock; asynchronous active-low reset
//   init_start/source : start a sweep, source node sampled with the pulse
//   init_done         : high while READY
//   a, b              : requester ports (slave side of the handshake)
//   ds_get_en/ds_set_en/ds_index/ds_wdata : registered store command
//   ds_rdata          : store read data, one cycle after ds_get_en
module distance_store_arbiter #(
  parameter int MAX_NODES   = 10,
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init_start,
  input  logic [INDEX_WIDTH-1:0] source,
  output logic                   init_done,
  distance_store_arbiter_if.slave a,
  distance_store_arbiter_if.slave b,
  output logic                   ds_get_en,
  output logic                   ds_set_en,
  output logic [INDEX_WIDTH-1:0] ds_index,
  output logic [VALUE_WIDTH-1:0] ds_wdata,
  input  logic [VALUE_WIDTH-1:0] ds_rdata
);
  localparam logic [VALUE_WIDTH-1:0] INF  = '1;
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(MAX_NODES - 1);

  typedef enum logic [1:0] {IDLE, INIT, READY} state_t;

  // Tag of a read travelling towards its rdata cycle.
  typedef struct packed {
    logic a;
    logic b;
    logic oor;
  } rd_tag_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;   // index shown on ds_index during INIT
  logic [INDEX_WIDTH-1:0] src_q, src_d;
  logic                   start;
  logic                   last_b_q;       // 1: b was granted most recently

  logic                   arb_en, a_gnt, b_gnt, any_gnt;
  logic                   sel_we, in_range;
  logic [INDEX_WIDTH-1:0] sel_idx;
  logic [VALUE_WIDTH-1:0] sel_wdata;

  logic                   get_d, set_d;
  logic [INDEX_WIDTH-1:0] idx_d;
  logic [VALUE_WIDTH-1:0] wd_d;
  rd_tag_t                tag_d;
  rd_tag_t [1:0]          rd_pipe;

  assign start = init_start && (state_q != INIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    case (state_q)
      IDLE, READY: if (start) begin
        state_d = INIT;
        cnt_d   = '0;
        src_d   = source;
      end
      INIT: begin
        if (cnt_q == LAST) state_d = READY;
        else               cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration: no grants outside READY, nor in the cycle a new sweep starts.
  assign arb_en   = (state_q == READY) && !init_start;
  assign a_gnt    = arb_en && a.req && (!b.req || last_b_q);
  assign b_gnt    = arb_en && b.req && !a_gnt;
  assign any_gnt  = a_gnt || b_gnt;
  assign a.gnt    = a_gnt;
  assign b.gnt    = b_gnt;

  assign sel_we    = a_gnt ? a.we    : b.we;
  assign sel_idx   = a_gnt ? a.index : b.index;
  assign sel_wdata = a_gnt ? a.wdata : b.wdata;
  assign in_range  = {1'b0, sel_idx} < (INDEX_WIDTH + 1)'(MAX_NODES);

  // Next store command. A sweep write is issued for every cycle that will be
  // spent in INIT, so the first one lands the cycle after init_start.
  always_comb begin
    get_d = 1'b0;
    set_d = 1'b0;
    idx_d = '0;
    wd_d  = '0;
    if (state_d == INIT) begin
      set_d = 1'b1;
      idx_d = cnt_d;
      wd_d  = (cnt_d == src_d) ? '0 : INF;
    end else if (any_gnt && in_range) begin
      get_d = !sel_we;
      set_d = sel_we;
      idx_d = sel_idx;
      wd_d  = sel_we ? sel_wdata : '0;
    end
  end

  // Out-of-range reads still travel the pipe so the requester gets INF back.
  always_comb begin
    tag_d     = '0;
    tag_d.a   = a_gnt && !a.we;
    tag_d.b   = b_gnt && !b.we;
    tag_d.oor = !in_range;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ds_get_en <= 1'b0;
      ds_set_en <= 1'b0;
      ds_index  <= '0;
      ds_wdata  <= '0;
      rd_pipe   <= '0;
      last_b_q  <= 1'b1;
    end else begin
      ds_get_en  <= get_d;
      ds_set_en  <= set_d;
      ds_index   <= idx_d;
      ds_wdata   <= wd_d;
      rd_pipe[0] <= tag_d;
      rd_pipe[1] <= rd_pipe[0];
      if (any_gnt) last_b_q <= b_gnt;
    end
  end

  assign init_done = (state_q == READY);
  assign a.rvalid  = rd_pipe[1].a;
  assign b.rvalid  = rd_pipe[1].b;
  assign a.rdata   = rd_pipe[1].a ? (rd_pipe[1].oor ? INF : ds_rdata) : '0;
  assign b.rdata   = rd_pipe[1].b ? (rd_pipe[1].oor ? INF : ds_rdata) : '0;
endmodule

// File: tb/tb_distance_store_arbiter.sv
module tb_distance_store_arbiter;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       init_start = 1'b0;
  logic [3:0] source = 4'd0;
  logic       init_done;
  logic       ds_get_en, ds_set_en;
  logic [3:0] ds_index;
  logic [7:0] ds_wdata;
  logic [7:0] ds_rdata = 8'h00;

  distance_store_arbiter_if #(.INDEX_WIDTH(4), .VALUE_WIDTH(8)) ia ();
  distance_store_arbiter_if #(.INDEX_WIDTH(4), .VALUE_WIDTH(8)) ib ();

  distance_store_arbiter #(.MAX_NODES(10), .INDEX_WIDTH(4), .VALUE_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .init_start(init_start), .source(source),
    .init_done(init_done), .a(ia), .b(ib),
    .ds_get_en(ds_get_en), .ds_set_en(ds_set_en), .ds_index(ds_index),
    .ds_wdata(ds_wdata), .ds_rdata(ds_rdata));

  always #5 clock = ~clock;

  // Behavioural DistanceStore: 16 words, 1-cycle read latency.
  logic [7:0] store [16];
  always @(posedge clock) begin
    if (ds_set_en) store[ds_index] <= ds_wdata;
    ds_rdata <= ds_get_en ? store[ds_index] : 8'h00;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick; @(posedge clock); #1; endtask
  task automatic mid;  @(negedge clock);     endtask

  // Reference model: expected distances, round-robin owner, store command
  // due next cycle, and reads due in one and two cycles.
  bit         model_on = 0;
  logic [7:0] mdist [16];
  logic       m_last_b, e_get, e_set, ea_m, eb_m, g_we;
  logic [3:0] e_idx, g_idx;
  logic [7:0] e_wd, g_wd;
  logic       p1_a, p1_b, p2_a, p2_b;
  logic [7:0] p1_val, p2_val;

  always @(negedge clock) if (model_on) begin
    ea_m = ia.req && (!ib.req || m_last_b);
    eb_m = ib.req && !ea_m;
    chk("m_a_gnt", ia.gnt, ea_m);
    chk("m_b_gnt", ib.gnt, eb_m);
    chk("m_get_en", ds_get_en, e_get);
    chk("m_set_en", ds_set_en, e_set);
    if (e_get || e_set) chk("m_index", ds_index, e_idx);
    if (e_set) chk("m_wdata", ds_wdata, e_wd);
    chk("m_a_rvalid", ia.rvalid, p2_a);
    chk("m_b_rvalid", ib.rvalid, p2_b);
    chk("m_a_rdata", ia.rdata, p2_a ? p2_val : 8'h00);
    chk("m_b_rdata", ib.rdata, p2_b ? p2_val : 8'h00);
    p2_a = p1_a; p2_b = p1_b; p2_val = p1_val;
    p1_a = 0; p1_b = 0; e_get = 0; e_set = 0;
    if (ea_m || eb_m) begin
      g_we  = ea_m ? ia.we    : ib.we;
      g_idx = ea_m ? ia.index : ib.index;
      g_wd  = ea_m ? ia.wdata : ib.wdata;
      m_last_b = eb_m;
      if (g_we) begin
        if (g_idx < 10) begin e_set = 1; e_idx = g_idx; e_wd = g_wd; mdist[g_idx] = g_wd; end
      end else begin
        if (g_idx < 10) begin e_get = 1; e_idx = g_idx; end
        p1_a = ea_m; p1_b = eb_m;
        p1_val = (g_idx < 10) ? mdist[g_idx] : 8'hFF;
      end
    end
  end

  // Checks the ten sweep cycles following an init_start cycle. A second
  // init_start is injected at iteration 'glitch' and must be ignored.
  task automatic check_sweep(input logic [3:0] src, input int glitch,
                             input bit rv_chk, input logic [7:0] rv_val);
    for (int i = 0; i < 10; i++) begin
      tick;
      init_start = (i == glitch);
      source     = (i == glitch) ? 4'd9 : src;
      mid;
      chk("sw_set_en", ds_set_en, 1);
      chk("sw_get_en", ds_get_en, 0);
      chk("sw_index", ds_index, i);
      chk("sw_wdata", ds_wdata, (i == src) ? 8'h00 : 8'hFF);
      chk("sw_no_gnt", ia.gnt | ib.gnt, 0);
      chk("sw_done_low", init_done, 0);
      if (i == 0 && rv_chk) begin
        chk("sw_b_rvalid", ib.rvalid, 1);
        chk("sw_b_rdata", ib.rdata, rv_val);
      end
    end
  endtask

  typedef struct {
    logic ar, aw; logic [3:0] ai; logic [7:0] ad;
    logic br, bw; logic [3:0] bi; logic [7:0] bd;
    logic ea, eb;
  } vec_t;
  vec_t tbl [12];

  bit   a_was_gnt, b_was_gnt, found;
  logic [7:0] saved3;

  initial begin
    tbl[0]  = '{1, 0, 4'd3,  8'h00, 1, 0, 4'd0,  8'h00, 1, 0};
    tbl[1]  = '{1, 0, 4'd3,  8'h00, 1, 0, 4'd0,  8'h00, 0, 1};
    tbl[2]  = '{1, 1, 4'd5,  8'h12, 0, 0, 4'd0,  8'h00, 1, 0};
    tbl[3]  = '{0, 0, 4'd0,  8'h00, 1, 0, 4'd5,  8'h00, 0, 1};
    tbl[4]  = '{1, 0, 4'd12, 8'h00, 0, 0, 4'd0,  8'h00, 1, 0};
    tbl[5]  = '{0, 0, 4'd0,  8'h00, 1, 1, 4'd12, 8'h55, 0, 1};
    tbl[6]  = '{0, 0, 4'd0,  8'h00, 0, 0, 4'd0,  8'h00, 0, 0};
    tbl[7]  = '{1, 1, 4'd9,  8'h07, 1, 1, 4'd9,  8'h08, 1, 0};
    tbl[8]  = '{1, 0, 4'd9,  8'h00, 1, 1, 4'd9,  8'h08, 0, 1};
    tbl[9]  = '{1, 0, 4'd9,  8'h00, 0, 0, 4'd0,  8'h00, 1, 0};
    tbl[10] = '{0, 0, 4'd0,  8'h00, 0, 0, 4'd0,  8'h00, 0, 0};
    tbl[11] = '{0, 0, 4'd0,  8'h00, 0, 0, 4'd0,  8'h00, 0, 0};
    for (int i = 0; i < 16; i++) store[i] = 8'hAA;

    ia.req = 1; ia.we = 0; ia.index = 0; ia.wdata = 0;
    ib.req = 0; ib.we = 0; ib.index = 0; ib.wdata = 0;

    // Reset state
    #2;
    chk("rst_get_en", ds_get_en, 0);
    chk("rst_set_en", ds_set_en, 0);
    chk("rst_index", ds_index, 0);
    chk("rst_wdata", ds_wdata, 0);
    chk("rst_done", init_done, 0);
    chk("rst_a_gnt", ia.gnt, 0);
    chk("rst_rvalid", ia.rvalid | ib.rvalid, 0);
    tick; reset = 1; ia.req = 0;

    // Sweep with source 3, both requesters holding row-0 requests throughout
    tick;
    ia.req = 1; ia.we = 0; ia.index = 3;
    ib.req = 1; ib.we = 0; ib.index = 0;
    init_start = 1; source = 3;
    mid;
    chk("idle_no_gnt", ia.gnt | ib.gnt, 0);
    check_sweep(4'd3, -1, 0, 8'h00);

    for (int i = 0; i < 16; i++) mdist[i] = (i == 3) ? 8'h00 : 8'hFF;
    m_last_b = 1; e_get = 0; e_set = 0; p1_a = 0; p1_b = 0; p2_a = 0; p2_b = 0;
    p1_val = 0; p2_val = 0;

    // Table of READY-phase vectors; model checks ds_* and read returns too
    for (int r = 0; r < 12; r++) begin
      tick;
      init_start = 0;
      model_on = 1;
      ia.req = tbl[r].ar; ia.we = tbl[r].aw; ia.index = tbl[r].ai; ia.wdata = tbl[r].ad;
      ib.req = tbl[r].br; ib.we = tbl[r].bw; ib.index = tbl[r].bi; ib.wdata = tbl[r].bd;
      mid;
      if (r == 0) chk("ready_done", init_done, 1);
      chk($sformatf("tbl%0d_a_gnt", r), ia.gnt, tbl[r].ea);
      chk($sformatf("tbl%0d_b_gnt", r), ib.gnt, tbl[r].eb);
    end

    // Randomised traffic, requests held until granted
    a_was_gnt = 1; b_was_gnt = 1;
    for (int c = 0; c < 400; c++) begin
      tick;
      if (!ia.req || a_was_gnt) begin
        ia.req = ($urandom_range(0, 2) != 0); ia.we = $urandom_range(0, 1);
        ia.index = $urandom_range(0, 15); ia.wdata = $urandom_range(0, 255);
      end
      if (!ib.req || b_was_gnt) begin
        ib.req = ($urandom_range(0, 2) != 0); ib.we = $urandom_range(0, 1);
        ib.index = $urandom_range(0, 15); ib.wdata = $urandom_range(0, 255);
      end
      mid;
      a_was_gnt = ia.gnt; b_was_gnt = ib.gnt;
    end
    for (int c = 0; c < 3; c++) begin
      tick; ia.req = 0; ib.req = 0; mid;
    end
    tick; model_on = 0;
    saved3 = mdist[3];

    // B read granted at N, init_start at N+1: read still returns, sweep follows
    ib.req = 1; ib.we = 0; ib.index = 3;
    mid;
    chk("t6_b_gnt", ib.gnt, 1);
    tick;
    ib.req = 0; ia.req = 1; ia.we = 0; ia.index = 1;
    init_start = 1; source = 7;
    mid;
    chk("t6_no_gnt_at_start", ia.gnt, 0);
    chk("t6_get_en", ds_get_en, 1);
    check_sweep(4'd7, -1, 1, saved3);
    tick; init_start = 0;
    mid;
    chk("t6_done", init_done, 1);
    chk("t6_held_gnt", ia.gnt, 1);
    tick; ia.req = 0;
    mid;
    chk("t6_a_get_en", ds_get_en, 1);
    chk("t6_a_index", ds_index, 1);
    tick; mid;
    chk("t6_a_rvalid", ia.rvalid, 1);
    chk("t6_a_rdata", ia.rdata, 8'hFF);

    // Reset in the middle of a sweep
    tick; init_start = 1; source = 2;
    mid;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick; init_start = 0; mid;
      if (ds_set_en && ds_index == 4) found = 1;
    end
    chk("t5_reach_idx4", found, 1);
    #1 reset = 0;
    #1;
    chk("t5_set_en_drop", ds_set_en, 0);
    chk("t5_done_low", init_done, 0);
    chk("t5_index_clr", ds_index, 0);
    tick; reset = 1; ia.req = 1; ia.we = 0; ia.index = 2;
    for (int k = 0; k < 5; k++) begin
      mid;
      chk("t5_no_gnt", ia.gnt, 0);
      chk("t5_idle_no_set", ds_set_en, 0);
      tick;
    end
    init_start = 1; source = 2;
    mid;
    chk("t5_start_no_gnt", ia.gnt, 0);
    check_sweep(4'd2, 4, 0, 8'h00);
    tick; init_start = 0;
    mid;
    chk("t5_done", init_done, 1);
    chk("t5_held_gnt", ia.gnt, 1);
    tick; ia.req = 0; mid;
    tick; mid;
    chk("t5_a_rvalid", ia.rvalid, 1);
    chk("t5_a_rdata_src", ia.rdata, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
